// File: rtl/store_if.sv
// Store port bundle: core-side request handshake, data-memory write channel
// and pipeline status flags.
interface store_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [1:0]            req_size;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  busy;
  logic                  done;
  logic                  misaligned;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           busy, done, misaligned
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           busy, done, misaligned
  );
endinterface

// File: rtl/store_unit.sv
// RV32I store alignment unit: steers SB/SH/SW data onto the byte lanes of a
// 32-bit memory write port with valid/ready handshakes on both sides.
module store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  store_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic                  accept_s;
  logic                  legal_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [3:0]            wstrb_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [3:0]            mem_wstrb_r;
  logic                  mem_valid_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  misaligned_r;

  // Natural alignment check: halves need an even address, words need offset 0.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      2'd0:    ok = 1'b1;
      2'd1:    ok = ~off[0];
      2'd2:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Lane steering, legality and next-state decode.
  always_comb begin
    state_s  = state_r;
    wdata_s  = bus.req_data;
    wstrb_s  = 4'b0000;
    accept_s = bus.req_valid && (state_r == IDLE);
    legal_s  = is_legal(bus.req_size, bus.req_addr[1:0]);
    case (bus.req_size)
      2'd0: begin
        wdata_s = {4{bus.req_data[7:0]}};
        wstrb_s = 4'b0001 << bus.req_addr[1:0];
      end
      2'd1: begin
        wdata_s = {2{bus.req_data[15:0]}};
        wstrb_s = 4'b0011 << bus.req_addr[1:0];
      end
      2'd2: begin
        wdata_s = bus.req_data;
        wstrb_s = 4'b1111;
      end
      default: begin
        wdata_s = bus.req_data;
        wstrb_s = 4'b0000;
      end
    endcase
    case (state_r)
      IDLE: begin
        if (accept_s && legal_s) begin
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (bus.mem_ready) begin
          state_s = IDLE;
        end else begin
          state_s = SEND;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered outputs; mem_* payload only loads on a legal accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      mem_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      misaligned_r <= 1'b0;
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= {DATA_WIDTH{1'b0}};
      mem_wstrb_r  <= 4'b0000;
    end else begin
      state_r      <= state_s;
      mem_valid_r  <= (state_s == SEND);
      busy_r       <= (state_s == SEND);
      done_r       <= (state_r == SEND) && bus.mem_ready;
      misaligned_r <= accept_s && !legal_s;
      if (accept_s && legal_s) begin
        mem_addr_r  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_r <= wdata_s;
        mem_wstrb_r <= wstrb_s;
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
        mem_wstrb_r <= mem_wstrb_r;
      end
    end
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.mem_valid  = mem_valid_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.mem_wstrb  = mem_wstrb_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.misaligned = misaligned_r;

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit: reset, lane steering, wait
// states, rejection, back-to-back throughput and asynchronous reset.
module tb_store_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   hs_cnt;

  store_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every memory handshake to detect lost or duplicated writes.
  always @(posedge clk) begin
    if (rst_n && bus.mem_valid && bus.mem_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = s;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    bus.mem_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.mem_valid, bus.busy, bus.done, bus.misaligned, bus.req_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_flags_in_reset got=%b exp=00001",
               {bus.mem_valid, bus.busy, bus.done, bus.misaligned, bus.req_ready});
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({bus.mem_valid, bus.busy, bus.done, bus.misaligned, bus.req_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_flags_after got=%b exp=00001",
               {bus.mem_valid, bus.busy, bus.done, bus.misaligned, bus.req_ready});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_payload got=%h/%h/%b exp=0/0/0000",
               bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
  endtask

  task automatic test_word;
    drive(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 2'd2);
    bus.mem_ready = 1'b1;
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    n_checks++;
    if ({bus.mem_valid, bus.busy, bus.req_ready, bus.done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL word_flags_n1 got=%b exp=1100",
               {bus.mem_valid, bus.busy, bus.req_ready, bus.done});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {32'h0000_1000, 32'hDEAD_BEEF, 4'b1111}) begin
      n_fail++;
      $display("FAIL word_payload got=%h/%h/%b exp=00001000/deadbeef/1111",
               bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    tick();
    n_checks++;
    if ({bus.mem_valid, bus.busy, bus.req_ready, bus.done} !== 4'b0011) begin
      n_fail++;
      $display("FAIL word_done_n2 got=%b exp=0011",
               {bus.mem_valid, bus.busy, bus.req_ready, bus.done});
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL word_done_single got=%b exp=0", bus.done);
    end
  endtask

  task automatic test_byte_lanes;
    logic [3:0] exp_strb [4];
    exp_strb[0] = 4'b0001;
    exp_strb[1] = 4'b0010;
    exp_strb[2] = 4'b0100;
    exp_strb[3] = 4'b1000;
    bus.mem_ready = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      drive(1'b1, 32'h0000_2000 + 32'(i), 32'h0000_00A5, 2'd0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'd0);
      n_checks++;
      if ({bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
          {1'b1, 32'h0000_2000, 32'hA5A5_A5A5, exp_strb[i]}) begin
        n_fail++;
        $display("FAIL byte_off%0d got=%b/%h/%h/%b exp=1/00002000/a5a5a5a5/%b", i,
                 bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, exp_strb[i]);
      end
      tick();
      n_checks++;
      if (bus.done !== 1'b1) begin
        n_fail++;
        $display("FAIL byte_done_off%0d got=%b exp=1", i, bus.done);
      end
    end
  endtask

  task automatic test_half_wait;
    drive(1'b1, 32'h0000_3002, 32'h1234_BEEF, 2'd1);
    bus.mem_ready = 1'b0;
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus.mem_valid, bus.busy, bus.req_ready, bus.done, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
          {4'b1100, 32'h0000_3000, 32'hBEEF_BEEF, 4'b1100}) begin
        n_fail++;
        $display("FAIL half_wait_cyc%0d got=%b/%h/%h/%b exp=1100/00003000/beefbeef/1100", i,
                 {bus.mem_valid, bus.busy, bus.req_ready, bus.done},
                 bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
      end
      if (i == 1) drive(1'b1, 32'h0000_5000, 32'hFFFF_FFFF, 2'd2);
      if (i == 2) drive(1'b0, 32'h0, 32'h0, 2'd0);
      if (i == 3) bus.mem_ready = 1'b1;
      tick();
    end
    n_checks++;
    if ({bus.mem_valid, bus.busy, bus.done, bus.mem_wdata, bus.mem_wstrb} !==
        {3'b001, 32'hBEEF_BEEF, 4'b1100}) begin
      n_fail++;
      $display("FAIL half_done got=%b/%h/%b exp=001/beefbeef/1100",
               {bus.mem_valid, bus.busy, bus.done}, bus.mem_wdata, bus.mem_wstrb);
    end
    tick();
    n_checks++;
    if ({bus.mem_valid, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL half_ignored_req got=%b exp=00", {bus.mem_valid, bus.done});
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] addr_t [3];
    logic [1:0]  size_t [3];
    addr_t[0] = 32'h0000_4001; size_t[0] = 2'd2;
    addr_t[1] = 32'h0000_4003; size_t[1] = 2'd1;
    addr_t[2] = 32'h0000_4000; size_t[2] = 2'd3;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, addr_t[i], 32'h5555_AAAA, size_t[i]);
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'd0);
      n_checks++;
      if ({bus.misaligned, bus.mem_valid, bus.busy, bus.req_ready} !== 4'b1001) begin
        n_fail++;
        $display("FAIL misaligned_%0d got=%b exp=1001", i,
                 {bus.misaligned, bus.mem_valid, bus.busy, bus.req_ready});
      end
      n_checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {32'h0000_3000, 32'hBEEF_BEEF, 4'b1100}) begin
        n_fail++;
        $display("FAIL misaligned_untouched_%0d got=%h/%h/%b exp=00003000/beefbeef/1100", i,
                 bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
      end
      tick();
      n_checks++;
      if ({bus.misaligned, bus.mem_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL misaligned_pulse_%0d got=%b exp=00", i, {bus.misaligned, bus.mem_valid});
      end
    end
  endtask

  task automatic test_back_to_back;
    int hs0;
    hs0 = hs_cnt;
    bus.mem_ready = 1'b1;
    drive(1'b1, 32'h0000_6004, 32'h1111_1111, 2'd2);
    tick();
    n_checks++;
    if ({bus.mem_valid, bus.req_ready, bus.mem_addr, bus.mem_wdata} !== {2'b10, 32'h0000_6004, 32'h1111_1111}) begin
      n_fail++;
      $display("FAIL b2b_first got=%b/%h/%h exp=10/00006004/11111111",
               {bus.mem_valid, bus.req_ready}, bus.mem_addr, bus.mem_wdata);
    end
    drive(1'b1, 32'h0000_6008, 32'h2222_2222, 2'd2);
    tick();
    n_checks++;
    if ({bus.mem_valid, bus.req_ready, bus.done} !== 3'b011) begin
      n_fail++;
      $display("FAIL b2b_done1 got=%b exp=011", {bus.mem_valid, bus.req_ready, bus.done});
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    n_checks++;
    if ({bus.mem_valid, bus.done, bus.mem_addr, bus.mem_wdata} !== {2'b10, 32'h0000_6008, 32'h2222_2222}) begin
      n_fail++;
      $display("FAIL b2b_second got=%b/%h/%h exp=10/00006008/22222222",
               {bus.mem_valid, bus.done}, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    n_checks++;
    if ({bus.mem_valid, bus.done} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_done2 got=%b exp=01", {bus.mem_valid, bus.done});
    end
    tick();
    n_checks++;
    if (hs_cnt - hs0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_write_count got=%0d exp=2", hs_cnt - hs0);
    end
  endtask

  task automatic test_async_reset;
    bus.mem_ready = 1'b0;
    drive(1'b1, 32'h0000_7000, 32'h0BAD_F00D, 2'd2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    n_checks++;
    if (bus.mem_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre got=%b exp=1", bus.mem_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_valid, bus.busy, bus.req_ready, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
        {3'b001, 68'h0}) begin
      n_fail++;
      $display("FAIL async_reset_mid_send got=%b/%h/%h/%b exp=001/0/0/0000",
               {bus.mem_valid, bus.busy, bus.req_ready}, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({bus.mem_valid, bus.busy, bus.done, bus.req_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL async_after_release got=%b exp=0001",
               {bus.mem_valid, bus.busy, bus.done, bus.req_ready});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    hs_cnt   = 0;
    test_reset();
    test_word();
    test_byte_lanes();
    test_half_wait();
    test_misaligned();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart of the core's result/load selection path.
- Where the mux4 picks one source onto the writeback bus, this block takes one store value and steers it out onto the correct byte lanes of the 32-bit data-memory write port.
- Sits between the MEM stage and data memory, with a valid/ready handshake on both sides. Handles RV32I SB/SH/SW alignment and byte-enable generation, and provides a stall indication to the pipeline.

Parameters:
- ADDR_WIDTH, 32, width of the byte address on both sides.
- DATA_WIDTH, 32, width of the store data and memory bus. Only 32 is supported; 4 byte lanes are fixed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core presents a store request
- req_ready  output  1  unit can accept a request
- req_addr  input  ADDR_WIDTH  byte address of the store
- req_data  input  DATA_WIDTH  store value, right-aligned (rs2)
- req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
- mem_valid  output  1  write request to data memory
- mem_ready  input  1  memory accepts the write
- mem_addr  output  ADDR_WIDTH  word-aligned address, {req_addr[ADDR_WIDTH-1:2],2'b00}
- mem_wdata  output  DATA_WIDTH  lane-replicated write data
- mem_wstrb  output  4  byte enables; bit i enables bits [8i+7:8i]
- busy  output  1  stall request to the pipeline
- done  output  1  one-cycle pulse when a write completes
- misaligned  output  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (rst_n low, asynchronous): state returns to IDLE immediately, including mid-transaction. An in-flight write is dropped; memory must tolerate mem_valid falling without a handshake.
- Values held during reset: mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0, misaligned=0.
- req_ready = (state==IDLE), so it reads 1 during and after reset. The core must not assert req_valid while in reset.
- State machine has two states, IDLE and SEND.
- IDLE, on the accept condition (req_valid && req_ready at a clock edge):
  - Misaligned or illegal request: pulse misaligned=1 for the next cycle, issue no memory request, stay in IDLE. This applies to size=3, size=1 with addr[0]=1, and size=2 with addr[1:0]!=0.
  - Legal request: register mem_addr, mem_wdata and mem_wstrb, then go to SEND.
- Lane rules for a legal request, with o = addr[1:0]:
  - Byte: mem_wdata = {4{data[7:0]}}, mem_wstrb = 4'b0001 << o.
  - Half: mem_wdata = {2{data[15:0]}}, mem_wstrb = 4'b0011 << o (o is 0 or 2).
  - Word: mem_wdata = data, mem_wstrb = 4'b1111.
- SEND:
  - mem_valid=1 and busy=1.
  - mem_addr, mem_wdata and mem_wstrb stay stable until the handshake.
  - req_valid is ignored; req_ready=0.
- Handshake: on mem_valid && mem_ready at a clock edge, the next cycle has state=IDLE, mem_valid=0, busy=0 and done=1 for exactly one cycle. mem_addr, mem_wdata and mem_wstrb hold their last values.
- Latency:
  - Accept at edge N gives mem_valid high in cycle N+1.
  - With mem_ready already high, the handshake is at edge N+1, done is high in cycle N+2, and the next accept is possible at edge N+2.
  - Peak throughput is one store per 2 cycles.
- mem_ready high while in IDLE has no effect.
- A rejected request never sets busy and never touches the mem_* outputs.
- Address bits [1:0] never reach mem_addr.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> all outputs 0 except req_ready=1. Assert rst_n=0 asynchronously mid-SEND -> mem_valid drops before the next edge.
- Word store: addr=0x1000, data=0xDEADBEEF, size=2, mem_ready=1 -> cycle N+1 shows mem_addr=0x1000, wdata=0xDEADBEEF, wstrb=1111; done pulse in N+2.
- Byte lanes: addr=0x2003, data=0x000000A5, size=0 -> wdata=0xA5A5A5A5, wstrb=1000, mem_addr=0x2000. Repeat for offsets 0/1/2 -> wstrb 0001/0010/0100.
- Half store with wait states: addr=0x3002, data=0x1234BEEF, size=1, mem_ready low for 3 cycles -> wdata=0xBEEFBEEF, wstrb=1100 held stable with busy=1 for 4 cycles, then done. A req_valid pulse during SEND is ignored.
- Misaligned: word at 0x4001, half at 0x4003, size=3 -> each gives a misaligned pulse, mem_valid stays 0, req_ready stays 1.
- Back-to-back: two legal stores presented continuously with mem_ready=1 -> second accepted exactly 2 cycles after the first; two done pulses, no lost or duplicated write.
